// File: rtl/dmac_copy_engine.sv
// Single-channel AXI3 copy engine: one read burst into a beat buffer, then one write burst out, per chunk.
// Optional response/rlast checking with an err output when DMAC_RESP_CHECK_EN is defined.
module dmac_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_BURST  = 16,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   src_addr,
    input  logic [ADDR_WIDTH-1:0]   dst_addr,
    input  logic [15:0]             byte_len,
    output logic                    busy,
    output logic                    done,
`ifdef DMAC_RESP_CHECK_EN
    output logic                    err,
`endif
    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [3:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [ID_WIDTH-1:0]     wid,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);

    // state   | meaning
    // S_IDLE  | waiting for start
    // S_RREQ  | AR request for the current chunk
    // S_RDATA | collecting read beats into the buffer
    // S_WREQ  | AW request for the current chunk
    // S_WDATA | draining the buffer on W
    // S_BRESP | waiting for the write response, then next chunk or done

    localparam int BPB = DATA_WIDTH / 8;
    localparam int SZ  = $clog2(BPB);
    localparam int PW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int BW  = $clog2(MAX_BURST + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RREQ, S_RDATA, S_WREQ, S_WDATA, S_BRESP
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d, dst_q, dst_d;
    logic [15:0]           rem_q, rem_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] buf_q [MAX_BURST];
    logic                  buf_we;

    logic [15:0]           words;
    logic [BW-1:0]         beats, last_idx;
    logic [15:0]           chunk_len;
    logic                  last_rd_beat, last_wr_beat, fin_chunk;
    logic                  unused_sig;

    assign words        = rem_q >> SZ;
    assign beats        = (words > 16'(MAX_BURST)) ? BW'(MAX_BURST) : words[BW-1:0];
    assign last_idx     = beats - BW'(1);
    assign chunk_len    = 16'(beats) << SZ;
    assign last_rd_beat = (wr_ptr_q == last_idx[PW-1:0]);
    assign last_wr_beat = (rd_ptr_q == last_idx[PW-1:0]);

`ifdef DMAC_RESP_CHECK_EN
    logic err_q, err_d;
    assign err       = err_q;
    // An error stops the copy after the chunk in flight has completed its B handshake.
    assign fin_chunk = (rem_q == chunk_len) || err_q || (bresp != 2'b00);
`else
    assign fin_chunk = (rem_q == chunk_len);
`endif

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign arid    = ID_WIDTH'(AXI_ID);
    assign awid    = ID_WIDTH'(AXI_ID);
    assign wid     = ID_WIDTH'(AXI_ID);
    assign araddr  = src_q;
    assign awaddr  = dst_q;
    assign arlen   = 4'(last_idx);
    assign awlen   = 4'(last_idx);
    assign arsize  = 3'(SZ);
    assign awsize  = 3'(SZ);
    assign arburst = 2'b01;
    assign awburst = 2'b01;
    assign wstrb   = '1;
    assign arvalid = (state_q == S_RREQ);
    assign rready  = (state_q == S_RDATA);
    assign awvalid = (state_q == S_WREQ);
    assign wvalid  = (state_q == S_WDATA);
    assign wlast   = (state_q == S_WDATA) && last_wr_beat;
    assign bready  = (state_q == S_BRESP);
    assign wdata   = buf_q[rd_ptr_q];

    assign unused_sig = ^{rid, bid, rresp, bresp, last_idx};

    always_comb begin
        state_d  = state_q;
        src_d    = src_q;
        dst_d    = dst_q;
        rem_d    = rem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        done_d   = 1'b0;
        buf_we   = 1'b0;
`ifdef DMAC_RESP_CHECK_EN
        err_d    = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef DMAC_RESP_CHECK_EN
                    err_d = 1'b0;
`endif
                    if (byte_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        rem_d   = byte_len;
                        state_d = S_RREQ;
                    end
                end
            end
            S_RREQ: begin
                if (arready) begin
                    wr_ptr_d = '0;
                    state_d  = S_RDATA;
                end
            end
            S_RDATA: begin
                if (rvalid) begin
                    buf_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PW'(1);
`ifdef DMAC_RESP_CHECK_EN
                    if ((rresp != 2'b00) || (rlast != last_rd_beat)) err_d = 1'b1;
`endif
                    if (rlast) state_d = S_WREQ;
                end
            end
            S_WREQ: begin
                if (awready) begin
                    rd_ptr_d = '0;
                    state_d  = S_WDATA;
                end
            end
            S_WDATA: begin
                if (wready) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                    if (last_wr_beat) state_d = S_BRESP;
                end
            end
            S_BRESP: begin
                if (bvalid) begin
                    src_d = src_q + ADDR_WIDTH'(chunk_len);
                    dst_d = dst_q + ADDR_WIDTH'(chunk_len);
                    rem_d = rem_q - chunk_len;
`ifdef DMAC_RESP_CHECK_EN
                    if (bresp != 2'b00) err_d = 1'b1;
`endif
                    if (fin_chunk) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RREQ;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            done_q   <= 1'b0;
`ifdef DMAC_RESP_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            done_q   <= done_d;
`ifdef DMAC_RESP_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Beat buffer holds data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[wr_ptr_q] <= rdata;
    end

endmodule

// File: tb/tb_dmac_copy_engine.sv
// Bench for dmac_copy_engine: randomized AXI slave memory plus a chunk/copy reference model.
// Define DMAC_RESP_CHECK_EN to also exercise the err path.
module tb_dmac_copy_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] byte_len;
    logic        busy, done;
`ifdef DMAC_RESP_CHECK_EN
    logic        err;
`endif
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    dmac_copy_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .byte_len(byte_len), .busy(busy), .done(done),
`ifdef DMAC_RESP_CHECK_EN
        .err(err),
`endif
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int checks = 0, failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
        end
    endtask

    // Slave memory and expected chunk lists
    logic [31:0] mem [0:16383];
    logic [31:0] exp_ar_addr[$], exp_aw_addr[$];
    logic [3:0]  exp_ar_len[$],  exp_aw_len[$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          p_rdy = 100, bmax = 0;
    logic [1:0]  next_bresp = 2'b00;
    int          done_cnt = 0, done_cyc = 0;
    bit          ar_f, r_f, aw_f, w_f, b_f;
    logic [31:0] ar_addr_c, aw_addr_c, wdata_c, rd_addr, wr_addr;
    logic [3:0]  ar_len_c, aw_len_c;
    logic        wlast_c;
    int          rd_left, wr_len, wr_cnt, b_dly;
    bit          b_pend;
    bit          ar_pv, aw_pv, w_pv;
    logic [31:0] ar_pa, aw_pa, w_pd;
    logic        w_pl;

    task automatic slave_reset();
        arready = 0; awready = 0; wready = 0; rvalid = 0; rlast = 0; bvalid = 0;
        rresp = 0; bresp = 0; rdata = 0; rid = 0; bid = 0;
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        rd_left = 0; wr_len = 0; wr_cnt = 0; b_pend = 0; b_dly = 0;
        ar_pv = 0; aw_pv = 0; w_pv = 0;
    endtask

    initial begin
        slave_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                slave_reset();
                continue;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            // valids hold with stable payload until their handshake
            if (ar_pv && !ar_f) check_eq("ar_stable", {arvalid, araddr}, {1'b1, ar_pa});
            if (aw_pv && !aw_f) check_eq("aw_stable", {awvalid, awaddr}, {1'b1, aw_pa});
            if (w_pv && !w_f)   check_eq("w_stable", {wvalid, wlast, wdata}, {1'b1, w_pl, w_pd});
            // handshakes completed on the posedge just passed
            if (ar_f) begin rd_addr = ar_addr_c; rd_left = int'(ar_len_c) + 1; end
            if (r_f)  begin rd_addr += 4; rd_left--; end
            if (aw_f) begin wr_addr = aw_addr_c; wr_len = int'(aw_len_c) + 1; wr_cnt = 0; end
            if (w_f) begin
                mem[int'(wr_addr[15:2]) + wr_cnt] = wdata_c;
                check_eq("wlast_pos", wlast_c, wr_cnt == wr_len - 1);
                wr_cnt++;
                if (wr_cnt == wr_len) begin b_pend = 1; b_dly = $urandom_range(0, bmax); end
            end
            if (b_f) begin
                b_pend = 0;
                check_eq("after_b_arvalid", arvalid, exp_ar_addr.size() > 0);
                check_eq("after_b_done", done, exp_ar_addr.size() == 0);
            end
            // new drives
            arready = arvalid && ($urandom_range(0, 99) < p_rdy);
            awready = awvalid && ($urandom_range(0, 99) < p_rdy);
            wready  = wvalid  && ($urandom_range(0, 99) < p_rdy);
            if (!(rvalid && !r_f)) begin
                if (rd_left > 0 && $urandom_range(0, 99) < p_rdy) begin
                    rvalid = 1; rdata = mem[int'(rd_addr[15:2])]; rlast = (rd_left == 1);
                end else begin
                    rvalid = 0; rlast = 0;
                end
            end
            if (!(bvalid && !b_f)) begin
                bvalid = 0;
                if (b_pend) begin
                    if (b_dly == 0) begin bvalid = 1; bresp = next_bresp; next_bresp = 0; end
                    else b_dly--;
                end
            end
            // handshakes that will complete on the next posedge
            ar_f = arvalid && arready;
            r_f  = rvalid && rready;
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            b_f  = bvalid && bready;
            if (ar_f) begin
                ar_addr_c = araddr; ar_len_c = arlen;
                check_eq("ar_attr", {arid, arsize, arburst}, {4'd0, 3'd2, 2'b01});
                if (exp_ar_addr.size() == 0) check_eq("ar_unexpected", 1, 0);
                else begin
                    check_eq("araddr", araddr, exp_ar_addr.pop_front());
                    check_eq("arlen", arlen, exp_ar_len.pop_front());
                end
            end
            if (aw_f) begin
                aw_addr_c = awaddr; aw_len_c = awlen;
                check_eq("aw_attr", {awid, awsize, awburst, wstrb}, {4'd0, 3'd2, 2'b01, 4'hF});
                if (exp_aw_addr.size() == 0) check_eq("aw_unexpected", 1, 0);
                else begin
                    check_eq("awaddr", awaddr, exp_aw_addr.pop_front());
                    check_eq("awlen", awlen, exp_aw_len.pop_front());
                end
            end
            if (w_f) begin wdata_c = wdata; wlast_c = wlast; end
            ar_pv = arvalid; ar_pa = araddr;
            aw_pv = awvalid; aw_pa = awaddr;
            w_pv = wvalid; w_pd = wdata; w_pl = wlast;
        end
    end

    // Reference: split the byte count into chunks of at most 16 words.
    task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int len);
        int rem, off, b;
        rem = len; off = 0;
        exp_ar_addr.delete(); exp_ar_len.delete(); exp_aw_addr.delete(); exp_aw_len.delete();
        while (rem > 0) begin
            b = (rem / 4 > 16) ? 16 : rem / 4;
            exp_ar_addr.push_back(s + 32'(off)); exp_ar_len.push_back(4'(b - 1));
            exp_aw_addr.push_back(d + 32'(off)); exp_aw_len.push_back(4'(b - 1));
            off += 4 * b; rem -= 4 * b;
        end
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int len,
                            input bit poke, input bit lat, input bit berr);
        logic [31:0] snap[$];
        int d0, c0, bad;
        build_exp(s, d, len);
        if (berr) while (exp_ar_addr.size() > 1) begin
            void'(exp_ar_addr.pop_back()); void'(exp_ar_len.pop_back());
            void'(exp_aw_addr.pop_back()); void'(exp_aw_len.pop_back());
        end
        for (int i = 0; i < len / 4; i++) snap.push_back(mem[int'(s[15:2]) + i]);
        @(negedge clk);
        check_eq("idle_before_start", busy, 0);
        src_addr = s; dst_addr = d; byte_len = 16'(len); start = 1;
        next_bresp = berr ? 2'd2 : 2'd0;
        d0 = done_cnt; c0 = cyc;
        @(negedge clk);
        start = 0;
        check_eq("busy_after_start", busy, len != 0);
        if (len == 0) check_eq("zero_len_done", done, 1);
        if (poke) begin
            repeat (2) @(negedge clk);
            src_addr = s + 32'h40; byte_len = 16'd8; start = 1;
            @(negedge clk);
            start = 0;
        end
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        check_eq("done_once", done_cnt - d0, 1);
        if (lat) check_eq("latency", done_cyc - c0, 2 * (len / 4) + 4);
        check_eq("ar_all_issued", exp_ar_addr.size(), 0);
        check_eq("aw_all_issued", exp_aw_addr.size(), 0);
        check_eq("busy_end", busy, 0);
        if (!berr) begin
            bad = 0;
            for (int i = 0; i < len / 4; i++)
                if (mem[int'(d[15:2]) + i] !== snap[i]) bad++;
            check_eq("mem_copy", bad, 0);
        end
`ifdef DMAC_RESP_CHECK_EN
        check_eq("err_flag", err, berr);
`endif
    endtask

    initial begin
        start = 0; src_addr = 0; dst_addr = 0; byte_len = 0;
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ctrl", {arvalid, rready, awvalid, wvalid, wlast, bready, done}, 0);
        check_eq("rst_const", {arsize, awsize, arburst, awburst, wstrb}, {3'd2, 3'd2, 2'b01, 2'b01, 4'hF});
        @(posedge clk); #2 rst_n = 1;

        p_rdy = 100; bmax = 0;
        run_copy(32'h0000, 32'h1000, 64, 0, 1, 0);
        run_copy(32'h0100, 32'h1100, 4, 0, 1, 0);
        p_rdy = 60; bmax = 3;
        run_copy(32'h0000, 32'h1000, 72, 0, 0, 0);
        run_copy(32'h0200, 32'h1200, 0, 0, 0, 0);
        run_copy(32'h0300, 32'h1300, 96, 1, 0, 0);

        // reset in the middle of the write data phase
        p_rdy = 70; bmax = 2;
        build_exp(32'h0400, 32'h1400, 64);
        @(negedge clk);
        src_addr = 32'h0400; dst_addr = 32'h1400; byte_len = 16'd64; start = 1;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 500 && !wvalid; i++) @(negedge clk);
        check_eq("reached_wdata", wvalid, 1);
        @(posedge clk); #2 rst_n = 0;
        #1;
        check_eq("rst_mid_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        check_eq("rst_mid_busy", busy, 0);
        repeat (3) @(negedge clk);
        check_eq("rst_hold_valids", {arvalid, rready, awvalid, wvalid, bready, done}, 0);
        @(posedge clk); #2 rst_n = 1;
        run_copy(32'h0400, 32'h1400, 64, 0, 0, 0);

        for (int t = 0; t < 8; t++) begin
            logic [31:0] s, d;
            p_rdy = $urandom_range(30, 100);
            bmax  = $urandom_range(0, 6);
            s = 32'($urandom_range(0, 4095)) << 2;
            d = 32'h8000 + (32'($urandom_range(0, 4095)) << 2);
            run_copy(s, d, 4 * $urandom_range(1, 150), 0, 0, 0);
        end

`ifdef DMAC_RESP_CHECK_EN
        p_rdy = 100; bmax = 1;
        run_copy(32'h0800, 32'h1800, 128, 0, 0, 1);
        run_copy(32'h0900, 32'h1900, 16, 0, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
